// File: rtl/rans_multi_stream_dec.sv
// Interleaved multi-lane rANS decoder: one shared decode engine, per-lane states, host-loaded tables.
// Optional end-of-block consistency check enabled by defining RANS_DEC_CHECK_EN.
module rans_multi_stream_dec #(
  parameter int RESOLUTION   = 10,
  parameter int SYMBOL_WIDTH = 8,
  parameter int NUM_RANS     = 4,
  parameter int LEN_WIDTH    = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          restart_i,
  input  logic [LEN_WIDTH-1:0]          len_i,
  input  logic                          freq_wr_i,
  input  logic [SYMBOL_WIDTH-1:0]       freq_addr_i,
  input  logic [RESOLUTION:0]           freq_i,
  input  logic [RESOLUTION-1:0]         cum_freq_i,
  input  logic                          slot_wr_i,
  input  logic [RESOLUTION-1:0]         slot_addr_i,
  input  logic [SYMBOL_WIDTH-1:0]       slot_symb_i,
  input  logic                          in_valid_i,
  output logic                          in_ready_o,
  input  logic [2*SYMBOL_WIDTH-1:0]     in_word_i,
  output logic                          symb_valid_o,
  input  logic                          symb_ready_i,
  output logic [SYMBOL_WIDTH-1:0]       symb_o,
  output logic [$clog2(NUM_RANS)-1:0]   lane_o,
  output logic                          done_o,
  output logic                          err_o
);

  localparam int W  = 2 * SYMBOL_WIDTH;
  localparam int S  = 4 * SYMBOL_WIDTH;
  localparam int LW = $clog2(NUM_RANS);
  localparam logic [S-1:0]  LOWER     = {{(S-W-1){1'b0}}, 1'b1, {W{1'b0}}};
  localparam logic [LW-1:0] LAST_LANE = LW'(NUM_RANS - 1);

  typedef enum logic [2:0] {
    IDLE, LOAD_HI, LOAD_LO, LOOKUP, CALC, EMIT, RENORM, DONE
  } state_e;

  state_e state_q, state_d;

  logic [RESOLUTION:0]     freq_mem [2**SYMBOL_WIDTH];
  logic [RESOLUTION-1:0]   cum_mem  [2**SYMBOL_WIDTH];
  logic [SYMBOL_WIDTH-1:0] slot_mem [2**RESOLUTION];

  logic [S-1:0]            x_q [NUM_RANS];
  logic [LW-1:0]           lane_q;
  logic [LEN_WIDTH-1:0]    count_q;
  logic [SYMBOL_WIDTH-1:0] sym_q;
  logic [SYMBOL_WIDTH-1:0] symb_q;
  logic [LW-1:0]           lane_out_q;

  logic                    in_acc, out_acc, tbl_wr_ok;
  logic [S-1:0]            x_cur, x_next;
  logic [RESOLUTION:0]     f_rd;
  logic [RESOLUTION-1:0]   c_rd;

  assign in_ready_o   = (state_q == LOAD_HI) || (state_q == LOAD_LO) || (state_q == RENORM);
  assign symb_valid_o = (state_q == EMIT);
  assign done_o       = (state_q == DONE);
  assign symb_o       = symb_q;
  assign lane_o       = lane_out_q;
  assign in_acc       = in_valid_i && in_ready_o;
  assign out_acc      = symb_valid_o && symb_ready_i;
  assign tbl_wr_ok    = (state_q == IDLE) || (state_q == DONE);

  // Table storage has no reset; contents survive reset and restart.
  always_ff @(posedge clk_i) begin
    if (tbl_wr_ok && freq_wr_i) begin
      freq_mem[freq_addr_i] <= freq_i;
      cum_mem[freq_addr_i]  <= cum_freq_i;
    end
    if (tbl_wr_ok && slot_wr_i) begin
      slot_mem[slot_addr_i] <= slot_symb_i;
    end
  end

  // sym_q is the registered address, so freq/cum are effectively a synchronous read in CALC.
  always_comb begin
    x_cur  = x_q[lane_q];
    f_rd   = freq_mem[sym_q];
    c_rd   = cum_mem[sym_q];
    x_next = S'(f_rd) * (x_cur >> RESOLUTION) + S'(x_cur[RESOLUTION-1:0]) - S'(c_rd);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = IDLE;
      LOAD_HI: if (in_acc) state_d = LOAD_LO;
      LOAD_LO: if (in_acc) begin
                 if (lane_q != LAST_LANE)  state_d = LOAD_HI;
                 else if (count_q == '0)   state_d = DONE;
                 else                      state_d = LOOKUP;
               end
      LOOKUP:  state_d = CALC;
      CALC:    state_d = EMIT;
      EMIT:    if (out_acc) begin
                 if (count_q == LEN_WIDTH'(1)) state_d = DONE;
                 else if (x_cur < LOWER)       state_d = RENORM;
                 else                          state_d = LOOKUP;
               end
      RENORM:  if (in_acc) state_d = LOOKUP;
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
    if (restart_i) state_d = LOAD_HI;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lane_q     <= '0;
      count_q    <= '0;
      sym_q      <= '0;
      symb_q     <= '0;
      lane_out_q <= '0;
      for (int unsigned i = 0; i < NUM_RANS; i++) x_q[i] <= '0;
    end else if (restart_i) begin
      lane_q  <= '0;
      count_q <= len_i;
    end else begin
      case (state_q)
        LOAD_HI: if (in_acc) x_q[lane_q][S-1:W] <= in_word_i;
        LOAD_LO: if (in_acc) begin
                   x_q[lane_q][W-1:0] <= in_word_i;
                   lane_q             <= lane_q + 1'b1;
                 end
        LOOKUP:  sym_q <= slot_mem[x_cur[RESOLUTION-1:0]];
        CALC:    begin
                   x_q[lane_q] <= x_next;
                   symb_q      <= sym_q;
                   lane_out_q  <= lane_q;
                 end
        EMIT:    if (out_acc) begin
                   count_q <= count_q - 1'b1;
                   if (count_q != LEN_WIDTH'(1) && x_cur >= LOWER) lane_q <= lane_q + 1'b1;
                 end
        RENORM:  if (in_acc) begin
                   x_q[lane_q] <= {x_cur[W-1:0], in_word_i};
                   lane_q      <= lane_q + 1'b1;
                 end
        default: ;
      endcase
    end
  end

`ifdef RANS_DEC_CHECK_EN
  logic         zf_q, err_q, lanes_bad;
  logic [S-1:0] x_chk;

  // Entry from LOAD_LO writes the last low word this same cycle, so fold it in here.
  always_comb begin
    lanes_bad = 1'b0;
    x_chk     = '0;
    for (int unsigned i = 0; i < NUM_RANS; i++) begin
      x_chk = x_q[i];
      if (state_q == LOAD_LO && LW'(i) == lane_q) x_chk[W-1:0] = in_word_i;
      if (x_chk != LOWER) lanes_bad = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      zf_q  <= 1'b0;
      err_q <= 1'b0;
    end else if (restart_i) begin
      zf_q  <= 1'b0;
      err_q <= 1'b0;
    end else begin
      if (state_q == CALC && f_rd == '0) zf_q <= 1'b1;
      if (state_q != DONE && state_d == DONE) err_q <= lanes_bad | zf_q;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_rans_multi_stream_dec.sv
// Scoreboard bench for rans_multi_stream_dec: directed blocks, expected symbols queued, monitor compares.
module tb_rans_multi_stream_dec;

  localparam int RES  = 10;
  localparam int SW   = 8;
  localparam int NR   = 4;
  localparam int LENW = 16;

`ifdef RANS_DEC_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic            restart_i;
  logic [LENW-1:0] len_i;
  logic            freq_wr_i;
  logic [SW-1:0]   freq_addr_i;
  logic [RES:0]    freq_i;
  logic [RES-1:0]  cum_freq_i;
  logic            slot_wr_i;
  logic [RES-1:0]  slot_addr_i;
  logic [SW-1:0]   slot_symb_i;
  logic            in_valid_i;
  logic            in_ready_o;
  logic [2*SW-1:0] in_word_i;
  logic            symb_valid_o;
  logic            symb_ready_i;
  logic [SW-1:0]   symb_o;
  logic [1:0]      lane_o;
  logic            done_o;
  logic            err_o;

  rans_multi_stream_dec #(
    .RESOLUTION(RES), .SYMBOL_WIDTH(SW), .NUM_RANS(NR), .LEN_WIDTH(LENW)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .restart_i(restart_i), .len_i(len_i),
    .freq_wr_i(freq_wr_i), .freq_addr_i(freq_addr_i), .freq_i(freq_i), .cum_freq_i(cum_freq_i),
    .slot_wr_i(slot_wr_i), .slot_addr_i(slot_addr_i), .slot_symb_i(slot_symb_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_word_i(in_word_i),
    .symb_valid_o(symb_valid_o), .symb_ready_i(symb_ready_i), .symb_o(symb_o),
    .lane_o(lane_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [SW-1:0] sym;
    logic [1:0]    lane;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted symbol is matched against the head of the queue.
  always @(negedge clk_i) begin
    if (rst_ni && symb_valid_o && symb_ready_i) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_symbol: got 0x%0h lane %0d expected none", symb_o, lane_o);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("symbol", 32'(symb_o), 32'(e.sym));
        check("lane",   32'(lane_o), 32'(e.lane));
      end
    end
  end

  task automatic push_exp(input logic [SW-1:0] s, input logic [1:0] l);
    exp_t e;
    e.sym  = s;
    e.lane = l;
    exp_q.push_back(e);
  endtask

  task automatic do_restart(input logic [LENW-1:0] len);
    @(posedge clk_i); #1;
    restart_i = 1'b1;
    len_i     = len;
    @(posedge clk_i); #1;
    restart_i = 1'b0;
  endtask

  task automatic send_word(input logic [2*SW-1:0] w);
    int unsigned n;
    n = 0;
    forever begin
      @(negedge clk_i);
      if (in_ready_o) break;
      n++;
      if (n > 300) begin
        n_checks++;
        n_fail++;
        $display("FAIL word_timeout: got in_ready_o=0 expected 1 for word 0x%0h", w);
        return;
      end
    end
    in_word_i  = w;
    in_valid_i = 1'b1;
    @(posedge clk_i); #1;
    in_valid_i = 1'b0;
  endtask

  task automatic load_lanes(input logic [31:0] x0, input logic [31:0] x1,
                            input logic [31:0] x2, input logic [31:0] x3);
    logic [31:0] xs [4];
    xs[0] = x0; xs[1] = x1; xs[2] = x2; xs[3] = x3;
    for (int i = 0; i < 4; i++) begin
      send_word(xs[i][31:16]);
      send_word(xs[i][15:0]);
    end
  endtask

  task automatic wait_done(input string name);
    int unsigned n;
    n = 0;
    while (!done_o && n < 300) begin
      @(negedge clk_i);
      n++;
    end
    check({name, "_done"}, 32'(done_o), 32'd1);
    check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_valid(input string name);
    int unsigned n;
    n = 0;
    @(negedge clk_i);
    while (!symb_valid_o && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    check({name, "_valid"}, 32'(symb_valid_o), 32'd1);
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, "_in_ready"},   32'(in_ready_o),   32'd0);
    check({name, "_symb_valid"}, 32'(symb_valid_o), 32'd0);
    check({name, "_symb"},       32'(symb_o),       32'd0);
    check({name, "_lane"},       32'(lane_o),       32'd0);
    check({name, "_done"},       32'(done_o),       32'd0);
    check({name, "_err"},        32'(err_o),        32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_ni       = 1'b1;
    restart_i    = 1'b0;
    len_i        = '0;
    freq_wr_i    = 1'b0;
    freq_addr_i  = '0;
    freq_i       = '0;
    cum_freq_i   = '0;
    slot_wr_i    = 1'b0;
    slot_addr_i  = '0;
    slot_symb_i  = '0;
    in_valid_i   = 1'b0;
    in_word_i    = '0;
    symb_ready_i = 1'b1;
    #2 rst_ni = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    check_outputs_zero("reset");
    rst_ni = 1'b1;

    // Tables: 0x41 owns slots 0..511, 0x42 owns 512..1023, each with freq 512.
    for (int i = 0; i < 1024; i++) begin
      @(posedge clk_i); #1;
      slot_wr_i   = 1'b1;
      slot_addr_i = RES'(i);
      slot_symb_i = (i < 512) ? 8'h41 : 8'h42;
      freq_wr_i   = (i < 2);
      freq_addr_i = (i == 0) ? 8'h41 : 8'h42;
      freq_i      = 11'd512;
      cum_freq_i  = (i == 0) ? 10'd0 : 10'd512;
    end
    @(posedge clk_i); #1;
    slot_wr_i = 1'b0;
    freq_wr_i = 1'b0;

    // Block A: x=0x10000 per lane -> 0x41, x'=0x8000 so lanes 0..2 renormalise.
    symb_ready_i = 1'b0;
    do_restart(16'd4);
    for (int i = 0; i < 4; i++) push_exp(8'h41, 2'(i));
    load_lanes(32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000);
    wait_valid("A_first");
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk_i);
      check("bp_symb",     32'(symb_o),       32'h41);
      check("bp_lane",     32'(lane_o),       32'd0);
      check("bp_in_ready", 32'(in_ready_o),   32'd0);
      check("bp_valid",    32'(symb_valid_o), 32'd1);
    end
    @(posedge clk_i); #1;
    symb_ready_i = 1'b1;
    begin
      int unsigned n;
      n = 0;
      @(negedge clk_i);
      while (!in_ready_o && n < 100) begin
        @(negedge clk_i);
        n++;
      end
    end
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk_i);
      check("stall_in_ready", 32'(in_ready_o),   32'd1);
      check("stall_valid",    32'(symb_valid_o), 32'd0);
    end
    send_word(16'h0000);
    send_word(16'h0000);
    send_word(16'h0000);
    wait_done("A");
    check("A_err", 32'(err_o), 32'(CHK));

    // Reset during CALC: outputs clear immediately, next block starts at lane 0.
    do_restart(16'd4);
    load_lanes(32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000);
    @(posedge clk_i); #1;
    rst_ni = 1'b0;
    #1;
    check_outputs_zero("midreset");
    @(posedge clk_i); #1;
    rst_ni = 1'b1;

    // Block B: alternating symbols, renorm words chosen so round two swaps symbols.
    do_restart(16'd8);
    push_exp(8'h41, 2'd0); push_exp(8'h42, 2'd1); push_exp(8'h41, 2'd2); push_exp(8'h42, 2'd3);
    push_exp(8'h42, 2'd0); push_exp(8'h41, 2'd1); push_exp(8'h42, 2'd2); push_exp(8'h41, 2'd3);
    load_lanes(32'h0001_0000, 32'h0001_0200, 32'h0001_0000, 32'h0001_0200);
    send_word(16'h0200);
    send_word(16'h0000);
    send_word(16'h0200);
    send_word(16'h0000);
    wait_done("B");
    check("B_err", 32'(err_o), 32'(CHK));

    // len 0: straight to DONE after the loads, no symbols.
    do_restart(16'd0);
    load_lanes(32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000);
    check("len0_done",  32'(done_o),       32'd1);
    check("len0_valid", 32'(symb_valid_o), 32'd0);
    check("len0_err",   32'(err_o),        32'd0);

    // Block C: x=0x20000 decodes to exactly L on every lane, clean check.
    do_restart(16'd4);
    for (int i = 0; i < 4; i++) push_exp(8'h41, 2'(i));
    load_lanes(32'h0002_0000, 32'h0002_0000, 32'h0002_0000, 32'h0002_0000);
    wait_done("C");
    check("C_err", 32'(err_o), 32'd0);

    // Block D: one corrupted load word leaves lane 2 at 0x10001.
    do_restart(16'd4);
    for (int i = 0; i < 4; i++) push_exp(8'h41, 2'(i));
    load_lanes(32'h0002_0000, 32'h0002_0000, 32'h0002_0001, 32'h0002_0000);
    wait_done("D");
    check("D_err", 32'(err_o), 32'(CHK));
    do_restart(16'd4);
    check("D_err_cleared", 32'(err_o),  32'd0);
    check("D_restart_rdy", 32'(in_ready_o), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
